// File: rtl/sensor_responder.sv
// sensor_responder: UART poll responder returning a sensor byte plus CRC-8, an alarm frame or a timeout error frame
module sensor_responder #(
   parameter logic [2:0]  SENSOR_ID  = 3'd1,
   parameter logic [7:0]  ALARM_BYTE = 8'hFF,
   parameter logic [15:0] TIMEOUT    = 16'd50000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       rx_rdy,
   input  logic [7:0] rx_data,
   output logic       rx_rdy_clr,
   output logic [7:0] tx_din,
   output logic       tx_wr_en,
   input  logic       tx_busy,
   input  logic [7:0] sensor_data,
   input  logic       sensor_valid,
   input  logic       alarm,
   output logic       alarm_latched,
   output logic       busy
);
   localparam logic [3:0] IDLE           = 4'd0;
   localparam logic [3:0] ACK            = 4'd1;
   localparam logic [3:0] WAIT_SENSOR    = 4'd2;
   localparam logic [3:0] CRC            = 4'd3;
   localparam logic [3:0] SEND_DATA      = 4'd4;
   localparam logic [3:0] WAIT_DATA_BUSY = 4'd5;
   localparam logic [3:0] WAIT_DATA_DONE = 4'd6;
   localparam logic [3:0] SEND_CRC       = 4'd7;
   localparam logic [3:0] WAIT_CRC_BUSY  = 4'd8;
   localparam logic [3:0] WAIT_CRC_DONE  = 4'd9;

   logic [3:0]  state_q, state_d;
   logic [2:0]  addr_q, addr_d;
   logic [7:0]  data_q, data_d;
   logic [7:0]  crc_q, crc_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [15:0] tmo_q, tmo_d;
   logic [7:0]  din_q, din_d;
   logic        alarm_q, alarm_d;
   logic        clr_c, wr_c;
   logic        unused_hi;

   assign unused_hi = ^rx_data[7:3];

   // Next-state logic; crc_q doubles as the second frame byte. With init 0 the
   // CRC register can start as the data byte and shift in zeros for 8 cycles.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      crc_d   = crc_q;
      cnt_d   = cnt_q;
      tmo_d   = tmo_q;
      din_d   = din_q;
      clr_c   = 1'b0;
      wr_c    = 1'b0;
      alarm_d = alarm | (alarm_q & ~(state_q == ACK && addr_q == 3'd0));
      case (state_q)
         IDLE: if (rx_rdy) begin
            clr_c   = 1'b1;
            addr_d  = rx_data[2:0];
            state_d = ACK;
         end
         ACK: if (addr_q == 3'd0 || addr_q != SENSOR_ID) state_d = IDLE;
            else if (alarm_q) begin
               data_d  = ALARM_BYTE;
               crc_d   = ALARM_BYTE;
               state_d = SEND_DATA;
            end else begin
               tmo_d   = 16'd0;
               state_d = WAIT_SENSOR;
            end
         WAIT_SENSOR: if (sensor_valid) begin
               data_d  = sensor_data;
               crc_d   = sensor_data;
               cnt_d   = 3'd0;
               state_d = CRC;
            end else if (tmo_q == TIMEOUT - 16'd1) begin
               data_d  = 8'h00;
               crc_d   = 8'hFF;
               state_d = SEND_DATA;
            end else if (tmo_q != 16'hFFFF) tmo_d = tmo_q + 16'd1;
         CRC: begin
            crc_d   = {crc_q[6:0], 1'b0} ^ (crc_q[7] ? 8'h07 : 8'h00);
            cnt_d   = cnt_q + 3'd1;
            state_d = (cnt_q == 3'd7) ? SEND_DATA : CRC;
         end
         SEND_DATA: if (!tx_busy) begin
            wr_c    = 1'b1;
            din_d   = data_q;
            state_d = WAIT_DATA_BUSY;
         end
         WAIT_DATA_BUSY: state_d = tx_busy ? WAIT_DATA_DONE : WAIT_DATA_BUSY;
         WAIT_DATA_DONE: state_d = tx_busy ? WAIT_DATA_DONE : SEND_CRC;
         SEND_CRC: if (!tx_busy) begin
            wr_c    = 1'b1;
            din_d   = crc_q;
            state_d = WAIT_CRC_BUSY;
         end
         WAIT_CRC_BUSY: state_d = tx_busy ? WAIT_CRC_DONE : WAIT_CRC_BUSY;
         WAIT_CRC_DONE: state_d = tx_busy ? WAIT_CRC_DONE : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State registers with synchronous reset
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= 3'd0;
         data_q  <= 8'h00;
         crc_q   <= 8'h00;
         cnt_q   <= 3'd0;
         tmo_q   <= 16'd0;
         din_q   <= 8'h00;
         alarm_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         crc_q   <= crc_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
         din_q   <= din_d;
         alarm_q <= alarm_d;
      end
   end

   // Strobes fire in the same cycle the condition is seen; reset masks them at once
   assign rx_rdy_clr    = clr_c & ~reset;
   assign tx_wr_en      = wr_c & ~reset;
   assign tx_din        = tx_wr_en ? din_d : din_q;
   assign alarm_latched = alarm_q;
   assign busy          = state_q != IDLE;
endmodule

// File: tb/tb_sensor_responder.sv
// tb_sensor_responder: scoreboard bench for sensor_responder with a UART transmitter model
module tb_sensor_responder;
   localparam logic [2:0]  ID  = 3'd1;
   localparam logic [7:0]  AB  = 8'hFF;
   localparam logic [15:0] TMO = 16'd40;

   logic       clock = 1'b0, reset = 1'b1, rx_rdy = 1'b0, sensor_valid = 1'b0, alarm = 1'b0, hold_busy = 1'b0;
   logic [7:0] rx_data = 8'h00, sensor_data = 8'h00;
   logic       rx_rdy_clr, tx_wr_en, tx_busy, alarm_latched, busy;
   logic [7:0] tx_din;

   sensor_responder #(.SENSOR_ID(ID), .ALARM_BYTE(AB), .TIMEOUT(TMO)) dut (
      .clock(clock), .reset(reset), .rx_rdy(rx_rdy), .rx_data(rx_data), .rx_rdy_clr(rx_rdy_clr),
      .tx_din(tx_din), .tx_wr_en(tx_wr_en), .tx_busy(tx_busy), .sensor_data(sensor_data),
      .sensor_valid(sensor_valid), .alarm(alarm), .alarm_latched(alarm_latched), .busy(busy)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int ucnt = 0;
   assign tx_busy = hold_busy | (ucnt != 0);
   always @(posedge clock) begin
      if (reset) ucnt <= 0;
      else if (tx_wr_en) ucnt <= int'($urandom_range(1, 6));
      else if (ucnt != 0) ucnt <= ucnt - 1;
   end

   logic [7:0] exp_q[$];
   int checks = 0, errors = 0, strobes = 0, clr_pulses = 0, polls = 0;
   int frame_start = 0, poll_cyc = 0, valid_cyc = 0, idle_cyc = 0, byte_idx = 0;
   bit seen_busy = 0, model_alarm = 0;
   logic [7:0] held_din = 8'h00;

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", n, a, e);
      end
   endtask

   function automatic logic [7:0] crc8(input logic [7:0] d);
      logic [7:0] c;
      c = 8'h00;
      for (int i = 7; i >= 0; i--) c = (c[7] ^ d[i]) ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
      return c;
   endfunction

   // Monitor: pops the expected byte on every strobe
   always @(negedge clock) begin
      if (reset) held_din = 8'h00;
      else begin
         if (rx_rdy_clr) clr_pulses++;
         if (tx_wr_en) begin
            strobes++;
            if (byte_idx == 0) frame_start = cyc;
            chk("strobe_while_busy", tx_busy, 0);
            if (byte_idx == 1) chk("busy_cycle_between_strobes", seen_busy, 1);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_strobe got %02h required no strobe", tx_din);
            end else chk("tx_din", tx_din, exp_q.pop_front());
            byte_idx = byte_idx ^ 1;
            seen_busy = 0;
            held_din = tx_din;
         end else begin
            if (tx_busy) seen_busy = 1;
            chk("tx_din_hold", tx_din, held_din);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic poll(input logic [7:0] b);
      bit got;
      got = 0;
      rx_data = b;
      rx_rdy = 1'b1;
      for (int i = 0; i < 3000 && !got; i++) begin
         @(negedge clock);
         if (rx_rdy_clr) got = 1;
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL poll_ack got none required rx_rdy_clr");
      end
      poll_cyc = cyc;
      polls++;
      @(posedge clock);
      #1;
      rx_rdy = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 4000 && busy; i++) tick(1);
      chk("return_to_idle", busy, 0);
      idle_cyc = cyc;
   endtask

   task automatic wait_strobe(input int n);
      for (int i = 0; i < 3000 && strobes < n; i++) tick(1);
      chk("strobe_seen", strobes >= n, 1);
   endtask

   task automatic pulse_alarm();
      alarm = 1'b1;
      tick(1);
      alarm = 1'b0;
      model_alarm = 1;
   endtask

   task automatic run_poll(input logic [7:0] b, input bit frame, input logic [7:0] e0, input logic [7:0] e1,
                           input bit give_valid, input int d, input logic [7:0] data,
                           input bit ack_alarm, input bit mid_alarm);
      int s0;
      s0 = strobes;
      if (frame) begin
         exp_q.push_back(e0);
         exp_q.push_back(e1);
      end
      poll(b);
      if (ack_alarm) pulse_alarm();
      else if (d > 1) tick(d - 1);
      if (give_valid) begin
         sensor_data = data;
         sensor_valid = 1'b1;
         valid_cyc = cyc;
         tick(1);
         sensor_valid = 1'b0;
      end
      if (mid_alarm) begin
         wait_strobe(s0 + 1);
         pulse_alarm();
      end
      wait_idle();
      chk("strobe_count", strobes - s0, frame ? 2 : 0);
      chk("alarm_latched", alarm_latched, model_alarm);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0, h0, hrel;
      logic [7:0] v;
      tick(3);
      chk("rst_tx_wr_en", tx_wr_en, 0);
      chk("rst_rx_rdy_clr", rx_rdy_clr, 0);
      chk("rst_tx_din", tx_din, 8'h00);
      chk("rst_busy", busy, 0);
      chk("rst_alarm_latched", alarm_latched, 0);
      reset = 1'b0;
      tick(2);

      // basic poll: data 01 -> 01,07, 1 capture + 8 CRC cycles before the strobe
      run_poll(8'h01, 1, 8'h01, 8'h07, 1, 2, 8'h01, 0, 0);
      chk("crc_latency", frame_start - valid_cyc, 9);

      // non-matching address
      run_poll(8'h03, 0, 0, 0, 0, 2, 8'h00, 0, 0);
      chk("mismatch_idle_time", (idle_cyc - poll_cyc) <= 2, 1);

      // upper bits ignored in the address
      run_poll(8'hF9, 1, 8'h5A, crc8(8'h5A), 1, 3, 8'h5A, 0, 0);

      // alarm frame, clear, then normal frame with FF
      tick(2);
      pulse_alarm();
      tick(1);
      run_poll(8'h01, 1, 8'hFF, 8'hFF, 1, 2, 8'h33, 0, 0);
      model_alarm = 0;
      run_poll(8'h00, 0, 0, 0, 0, 2, 8'h00, 0, 0);
      run_poll(8'h01, 1, 8'hFF, 8'hF3, 1, 2, 8'hFF, 0, 0);

      // set wins over address-0 clear in the same cycle
      model_alarm = 0;
      run_poll(8'h00, 0, 0, 0, 0, 2, 8'h00, 1, 0);
      model_alarm = 0;
      run_poll(8'h00, 0, 0, 0, 0, 2, 8'h00, 0, 0);

      // alarm during a frame does not change it; next poll sends the alarm frame
      run_poll(8'h01, 1, 8'h80, crc8(8'h80), 1, 4, 8'h80, 0, 1);
      run_poll(8'h01, 1, AB, AB, 1, 2, 8'h11, 0, 0);
      model_alarm = 0;
      run_poll(8'h00, 0, 0, 0, 0, 2, 8'h00, 0, 0);

      // timeout frame
      run_poll(8'h01, 1, 8'h00, 8'hFF, 0, 2, 8'h00, 0, 0);
      hrel = frame_start - (poll_cyc + 1);
      chk("timeout_start", (hrel >= int'(TMO)) && (hrel <= int'(TMO) + 1), 1);

      // transmitter busy for 100 cycles before the first byte
      s0 = strobes;
      hold_busy = 1'b1;
      h0 = cyc;
      exp_q.push_back(8'hA5);
      exp_q.push_back(crc8(8'hA5));
      poll(8'h01);
      tick(1);
      sensor_data = 8'hA5;
      sensor_valid = 1'b1;
      tick(1);
      sensor_valid = 1'b0;
      while (cyc < h0 + 100) tick(1);
      chk("no_strobe_while_held", strobes - s0, 0);
      hold_busy = 1'b0;
      hrel = cyc;
      wait_idle();
      chk("strobe_on_busy_release", frame_start, hrel);
      chk("held_strobe_count", strobes - s0, 2);

      // reset between the two strobes
      s0 = strobes;
      exp_q.push_back(8'h3C);
      exp_q.push_back(crc8(8'h3C));
      poll(8'h01);
      tick(1);
      sensor_data = 8'h3C;
      sensor_valid = 1'b1;
      tick(1);
      sensor_valid = 1'b0;
      wait_strobe(s0 + 1);
      pulse_alarm();
      reset = 1'b1;
      exp_q.delete();
      byte_idx = 0;
      seen_busy = 0;
      model_alarm = 0;
      tick(1);
      @(negedge clock);
      chk("mid_rst_tx_wr_en", tx_wr_en, 0);
      chk("mid_rst_tx_din", tx_din, 8'h00);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_alarm", alarm_latched, 0);
      chk("mid_rst_rx_rdy_clr", rx_rdy_clr, 0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      tick(20);
      chk("no_strobe_after_reset", strobes - s0, 1);
      run_poll(8'h01, 1, 8'hC3, crc8(8'hC3), 1, 2, 8'hC3, 0, 0);

      // randomized polls against the frame model
      for (int k = 0; k < 30; k++) begin
         logic [2:0] a;
         int r, d;
         bit gv, fr;
         r = int'($urandom_range(0, 3));
         a = (r == 0) ? 3'd0 : (r < 3) ? ID : 3'($urandom_range(2, 7));
         if ($urandom_range(0, 3) == 0) begin
            pulse_alarm();
            tick(1);
         end
         gv = $urandom_range(0, 7) != 0;
         d = int'($urandom_range(2, 8));
         v = 8'($urandom);
         fr = a == ID;
         if (a == 3'd0) begin
            model_alarm = 0;
            run_poll({5'($urandom), a}, 0, 0, 0, 0, 2, v, 0, 0);
         end else if (fr && model_alarm) run_poll({5'($urandom), a}, 1, AB, AB, gv, d, v, 0, 0);
         else if (fr && gv) run_poll({5'($urandom), a}, 1, v, crc8(v), 1, d, v, 0, 0);
         else if (fr) run_poll({5'($urandom), a}, 1, 8'h00, 8'hFF, 0, d, v, 0, 0);
         else run_poll({5'($urandom), a}, 0, 0, 0, gv, d, v, 0, 0);
         tick(int'($urandom_range(1, 4)));
      end

      chk("rx_rdy_clr_count", clr_pulses, polls);
      chk("queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
